// File: rtl/if_id_fetch_queue.sv
// ============================================================================
// if_id_fetch_queue
// ----------------------------------------------------------------------------
// Decoupling queue between the IF and ID stages. It holds up to DEPTH
// {pc, inst} pairs in a circular buffer, so fetch can keep running while
// decode is stalled. Both sides use valid/ready handshakes. A flush, raised on
// a taken branch or redirect, discards every buffered instruction on the next
// edge.
//
// Parameters
//   ADDR_W  width of the pc field
//   INST_W  width of the instruction field
//   DEPTH   number of entries (power of two, >= 2)
//   CNT_W   width of the occupancy count
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active high; wins over every other input
//   flush_i    discard all entries; blocks push and pop in the same cycle
//   in_valid   IF presents {in_pc, in_inst}
//   in_ready   queue accepts a beat this cycle (independent of out_ready)
//   in_pc      pc of the fetched instruction
//   in_inst    fetched instruction word
//   out_valid  head entry available to ID
//   out_ready  ID consumes the head this cycle
//   out_pc     pc of the head entry, zero when out_valid=0
//   out_inst   instruction of the head entry, zero when out_valid=0
//   count_o    current occupancy, 0..DEPTH
//
// Build option
//   IF_ID_BYPASS_EN  When defined and the queue is empty, an incoming beat is
//                    shown on the output in the same cycle. If ID takes it in
//                    that cycle, it is never written. When undefined, a beat
//                    takes at least one cycle to reach the output.
// ============================================================================
module if_id_fetch_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [CNT_W-1:0]  count_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("if_id_fetch_queue: DEPTH must be a power of two and at least 2");
    end

    // Storage is never reset. Only entries between rd_ptr and wr_ptr are ever
    // read, so their stale contents are never seen.
    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
    logic [ADDR_W-1:0] mem_pc_d   [DEPTH];
    logic [INST_W-1:0] mem_inst_q [DEPTH];
    logic [INST_W-1:0] mem_inst_d [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic stored_valid;
    logic bypass_vis;
    logic bypass_take;
    logic push;
    logic pop;

    // ------------------------------------------------------------------
    // Handshake and output selection
    // ------------------------------------------------------------------
    always_comb begin
        in_ready     = (count_q != FULL_CNT) && !flush_i;
        stored_valid = (count_q != '0) && !flush_i;

`ifdef IF_ID_BYPASS_EN
        // The queue is empty, so the incoming beat becomes the head at once.
        bypass_vis   = (count_q == '0) && !flush_i && in_valid;
`else
        bypass_vis   = 1'b0;
`endif

        out_valid    = stored_valid || bypass_vis;
        bypass_take  = bypass_vis && out_ready;

        // A beat that ID takes directly is never written.
        push         = in_valid && in_ready && !bypass_take;
        pop          = stored_valid && out_ready;

        if (stored_valid) begin
            out_pc   = mem_pc_q[rd_ptr_q];
            out_inst = mem_inst_q[rd_ptr_q];
        end else if (bypass_vis) begin
            out_pc   = in_pc;
            out_inst = in_inst;
        end else begin
            out_pc   = '0;
            out_inst = '0;
        end

        count_o      = count_q;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        mem_pc_d   = mem_pc_q;
        mem_inst_d = mem_inst_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (push) begin
            mem_pc_d[wr_ptr_q]   = in_pc;
            mem_inst_d[wr_ptr_q] = in_inst;
            // DEPTH is a power of two, so natural overflow wraps the pointer.
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // push and pop are already blocked during a flush, so only the
        // pointers and count need clearing. Storage may keep its old contents.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_pc_q   <= mem_pc_d;
        mem_inst_q <= mem_inst_d;
    end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
module tb_if_id_fetch_queue;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic [INST_W-1:0] in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic [CNT_W-1:0]  count_o;

    if_id_fetch_queue #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush_i),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_inst  (in_inst),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_inst (out_inst),
        .count_o  (count_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle, checks the outputs against the scoreboard before the
    // edge, and then updates the scoreboard to match what the edge commits.
    task automatic step(input logic iv, input logic [ADDR_W-1:0] pc,
                        input logic [INST_W-1:0] inst, input logic ordy,
                        input logic fl);
        int                n;
        logic              e_rdy;
        logic              e_ov;
        logic              byp;
        logic [ADDR_W-1:0] e_pc;
        logic [INST_W-1:0] e_inst;

        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush_i   = fl;
        @(negedge clk);

        n      = sb.size();
        e_rdy  = (n != DEPTH) && !fl;
        e_ov   = (n != 0) && !fl;
        byp    = 1'b0;
        e_pc   = e_ov ? sb[0].pc   : '0;
        e_inst = e_ov ? sb[0].inst : '0;
`ifdef IF_ID_BYPASS_EN
        if (n == 0 && !fl && iv) begin
            byp    = 1'b1;
            e_ov   = 1'b1;
            e_pc   = pc;
            e_inst = inst;
        end
`endif
        chk("in_ready",  64'(in_ready),  64'(e_rdy));
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        chk("out_pc",    64'(out_pc),    64'(e_pc));
        chk("out_inst",  64'(out_inst),  64'(e_inst));
        chk("count_o",   64'(count_o),   64'(n));

        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (e_ov && ordy && !byp) void'(sb.pop_front());
            if (iv && e_rdy && !(byp && ordy)) sb.push_back({pc, inst});
        end
        #1;
    endtask

    task automatic do_reset(input logic iv, input logic fl);
        rst      = 1'b1;
        in_valid = iv;
        flush_i  = fl;
        in_pc    = 32'h0000_0999;
        in_inst  = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        rst       = 1'b1;
        flush_i   = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;

        // Reset, then idle.
        do_reset(1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Fill with ID stalled, then offer a fifth beat, which is rejected.
        for (int k = 0; k < 4; k++)
            step(1'b1, 32'(4 * k), 32'h13 + 32'(k), 1'b0, 1'b0);
        step(1'b1, 32'h10, 32'h17, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // A full queue refuses a beat even while a pop happens in the same cycle.
        step(1'b1, 32'h14, 32'h18, 1'b1, 1'b0);

        // Drain the rest in order, then check the queue is empty.
        for (int k = 0; k < 3; k++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Bring the pointers to wr=3 with count=2, then push and pop together
        // so the pointers wrap through 0.
        step(1'b1, 32'h1C, 32'hA1, 1'b0, 1'b0);
        step(1'b0, 32'h0,  32'h0,  1'b1, 1'b0);
        step(1'b1, 32'h20, 32'hA2, 1'b0, 1'b0);
        step(1'b1, 32'h24, 32'hA3, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++)
            step(1'b1, 32'h28 + 32'(4 * k), 32'hB0 + 32'(k), 1'b1, 1'b0);

        // Flush at count=3 while a beat is offered. That beat must never appear.
        step(1'b1, 32'h3C, 32'hC0, 1'b0, 1'b0);
        step(1'b1, 32'h40, 32'hC1, 1'b0, 1'b1);
        step(1'b1, 32'h80, 32'hC2, 1'b0, 1'b0);
        step(1'b0, 32'h0,  32'h0,  1'b1, 1'b0);
        step(1'b0, 32'h0,  32'h0,  1'b1, 1'b0);

        // Offer a beat to the empty queue with ID ready. With the bypass
        // option it comes out in the same cycle; without it, one cycle later.
        step(1'b1, 32'h100, 32'hD0, 1'b1, 1'b0);
        step(1'b0, 32'h0,   32'h0,  1'b1, 1'b0);
        step(1'b0, 32'h0,   32'h0,  1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 80; i++)
            step(1'($urandom_range(0, 1)), 32'h200 + 32'(4 * i), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));

        // Reset mid-stream while a flush and a beat are also present.
        step(1'b1, 32'h300, 32'hE0, 1'b0, 1'b0);
        step(1'b1, 32'h304, 32'hE1, 1'b0, 1'b0);
        do_reset(1'b1, 1'b1);
        step(1'b0, 32'h0,   32'h0,  1'b0, 1'b0);
        step(1'b1, 32'h400, 32'hF0, 1'b0, 1'b0);
        step(1'b0, 32'h0,   32'h0,  1'b1, 1'b0);
        step(1'b0, 32'h0,   32'h0,  1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
